// File: rtl/dff_pkg.sv
// Shared constants for the d_flip_flop register slice: default width/reset value
// and the reset-value range check used at elaboration.
package dff_pkg;

    localparam int              DFF_MAX_WIDTH       = 64;
    localparam int              DFF_DEFAULT_WIDTH   = 1;
    localparam logic [63:0]     DFF_DEFAULT_RST_VAL = 64'h0000_0000_0000_0000;

    // True when no bit of value is set at or above position width.
    function automatic bit dff_rst_val_fits(input logic [63:0] value, input int width);
        bit fits_s;
        if (width >= DFF_MAX_WIDTH) begin
            fits_s = 1'b1;
        end else begin
            fits_s = ((value >> width) == 64'h0000_0000_0000_0000);
        end
        return fits_s;
    endfunction

endpackage

// File: rtl/d_flip_flop_if.sv
// Data-side bundle of the register slice: d toward the flops, q back from them.
interface d_flip_flop_if
    import dff_pkg::*;
#(
    parameter int WIDTH = DFF_DEFAULT_WIDTH
);
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;

    modport master (output d, input  q);
    modport slave  (input  d, output q);
endinterface

// File: rtl/dff_bit.sv
// Single-bit flop with asynchronous active-low reset to a per-bit reset value.
module dff_bit #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic q_r;

    // Capture d on rising clk; reset forces RST_VAL without waiting for a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_r <= RST_VAL;
        end else begin
            q_r <= d;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/d_flip_flop.sv
// WIDTH-bit register built from independent dff_bit cells; each bit carries its
// own slice of RST_VAL so the reset pattern is fixed per bit at elaboration.
module d_flip_flop
    import dff_pkg::*;
#(
    parameter int          WIDTH   = DFF_DEFAULT_WIDTH,
    parameter logic [63:0] RST_VAL = DFF_DEFAULT_RST_VAL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    // Reject illegal configurations before any hardware is built.
    if ((WIDTH < 1) || (WIDTH > DFF_MAX_WIDTH)) begin : g_bad_width
        $error("d_flip_flop: WIDTH=%0d outside 1..%0d", WIDTH, DFF_MAX_WIDTH);
    end
    if (!dff_rst_val_fits(RST_VAL, WIDTH)) begin : g_bad_rst_val
        $error("d_flip_flop: RST_VAL 0x%0h wider than WIDTH=%0d", RST_VAL, WIDTH);
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dff_bit #(
            .RST_VAL (RST_VAL[i])
        ) u_bit (
            .clk (clk),
            .rst (rst),
            .d   (D[i]),
            .q   (Q[i])
        );
    end

endmodule

// File: tb/tb_d_flip_flop.sv
// Directed and table-driven checks of d_flip_flop at WIDTH=1 (default reset) and
// WIDTH=8 (reset 8'hA5), followed by a model-checked random run.
module tb_d_flip_flop;
    import dff_pkg::*;

    localparam logic [7:0] RV8 = 8'hA5;

    typedef struct {
        logic       rst;
        logic       d1;
        logic [7:0] d8;
        logic       exp1;
        logic [7:0] exp8;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    logic       m1;
    logic [7:0] m8;
    vec_t       tbl [11];

    d_flip_flop_if #(.WIDTH(1)) bus1 ();
    d_flip_flop_if #(.WIDTH(8)) bus8 ();

    d_flip_flop dut1 (
        .clk (clk),
        .rst (rst),
        .D   (bus1.d),
        .Q   (bus1.q)
    );

    d_flip_flop #(
        .WIDTH   (8),
        .RST_VAL (64'h0000_0000_0000_00A5)
    ) dut8 (
        .clk (clk),
        .rst (rst),
        .D   (bus8.d),
        .Q   (bus8.q)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, got, exp);
        end
    endtask

    task automatic check_both(input string name, input logic e1, input logic [7:0] e8);
        check({name, "_q1"}, {63'd0, bus1.q}, {63'd0, e1});
        check({name, "_q8"}, {56'd0, bus8.q}, {56'd0, e8});
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 1'b1, 8'hFF, 1'b1, 8'hFF};
        tbl[2]  = '{1'b1, 1'b1, 8'h81, 1'b1, 8'h81};
        tbl[3]  = '{1'b0, 1'b1, 8'h7E, 1'b0, RV8};
        tbl[4]  = '{1'b0, 1'b0, 8'h11, 1'b0, RV8};
        tbl[5]  = '{1'b1, 1'b1, 8'h22, 1'b1, 8'h22};
        tbl[6]  = '{1'b1, 1'b0, 8'hA5, 1'b0, 8'hA5};
        tbl[7]  = '{1'b1, 1'b1, 8'h5A, 1'b1, 8'h5A};
        tbl[8]  = '{1'b0, 1'b1, 8'hFF, 1'b0, RV8};
        tbl[9]  = '{1'b1, 1'b0, 8'h01, 1'b0, 8'h01};
        tbl[10] = '{1'b1, 1'b1, 8'h80, 1'b1, 8'h80};

        // Power-up in reset with D toggling across rising edges 10..90 ns.
        rst    = 1'b0;
        bus1.d = 1'b0;
        bus8.d = 8'h3C;
        for (int i = 1; i < 20; i++) begin
            #5;
            bus1.d = ~bus1.d;
            bus8.d = bus8.d ^ 8'hFF;
            check("por_q1", {63'd0, bus1.q}, 64'd0);
            if (i >= 3) check("por_q8", {56'd0, bus8.q}, {56'd0, RV8});
        end

        // Release on the 100 ns falling edge; first capture at 110 ns.
        #5;
        bus1.d = 1'b1;
        bus8.d = 8'h3C;
        rst    = 1'b1;
        #1  check_both("release_hold", 1'b0, RV8);
        #10 check_both("first_capture", 1'b1, 8'h3C);

        // D pulses between edges; only the value at the 130 ns edge counts.
        #2 bus1.d = 1'b0;
        #3 bus1.d = 1'b1;
        #1 check("mid_cycle_hold", {63'd0, bus1.q}, 64'd1);
        #7 bus1.d = 1'b0;
        #7 check("edge_value", {63'd0, bus1.q}, 64'd0);

        #9 begin bus1.d = 1'b1; bus8.d = 8'hC3; end
        #11 check_both("load_before_reset", 1'b1, 8'hC3);

        // Asynchronous assert at 200 ns, held across edges 210 and 230.
        #49 rst = 1'b0;
        #1  check_both("async_assert", 1'b0, RV8);
        #4  begin bus1.d = 1'b0; bus1.d = 1'b1; bus8.d = 8'hFF; end
        #26 check_both("reset_held", 1'b0, RV8);
        #9  begin rst = 1'b1; bus1.d = 1'b1; bus8.d = 8'h5A; end
        #1  check_both("second_release_hold", 1'b0, RV8);
        #10 check_both("second_capture", 1'b1, 8'h5A);

        // Table: inputs applied on the falling edge, result checked after the rising edge.
        for (int v = 0; v < 11; v++) begin
            @(negedge clk);
            rst    = tbl[v].rst;
            bus1.d = tbl[v].d1;
            bus8.d = tbl[v].d8;
            #1;
            if (!tbl[v].rst) check_both("tbl_async", 1'b0, RV8);
            @(posedge clk);
            #1 check_both("tbl_edge", tbl[v].exp1, tbl[v].exp8);
        end

        // Random run: D and rst change every 100 ns, scoreboard tracks expected Q.
        m1 = 1'b1;
        m8 = 8'h80;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if ((c % 5) == 0) begin
                bus1.d = 1'($urandom);
                bus8.d = 8'($urandom);
                rst    = ~rst;
            end
            #1;
            if (!rst) begin
                m1 = 1'b0;
                m8 = RV8;
            end
            check_both("rnd_neg", m1, m8);
            @(posedge clk);
            #1;
            if (rst) begin
                m1 = bus1.d;
                m8 = bus8.d;
            end else begin
                m1 = 1'b0;
                m8 = RV8;
            end
            check_both("rnd_pos", m1, m8);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
